lf_cmd_decoder: RTL and testbench

- Next-generation LF configuration front end. Replaces the ncs/spck-clocked config latches with a fully synchronous SPI slave in the pck0 domain.
- Takes 16-bit command frames from the ARM and decodes them into conf_word, divisor and a parametrised bank of user registers.
- Adds frame-error detection, a one-cycle config-change strobe and optional register readback on miso.
- Sits between the SPI pins and the clk_divider / mode muxes of the LF top level.

---
 rtl/lf_cmd_decoder.sv | 196 +++++++++++++++++++
 tb/tb_lf_cmd_decoder.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/lf_cmd_decoder.sv
// LF configuration front end: synchronous SPI slave in the pck0 domain that decodes
// 16-bit command frames into conf_word, divisor and user registers. Define
// LF_CMD_READBACK_EN to enable register readback on miso.
//
// Frame layout (16 bits, MSB first): [15:12] opcode, [DATA_W-1:0] payload.
// Bits between the opcode and the payload are ignored.
module lf_cmd_decoder #(
    parameter int                DATA_W        = 8,
    parameter int                NUM_USER_REGS = 2,
    parameter logic [DATA_W-1:0] EDGE_CONF     = 8'h01,
    parameter int                DEFAULT_THR   = 127
) (
    input  logic                            pck0,
    input  logic                            rst,
    input  logic                            spck,
    input  logic                            mosi,
    input  logic                            ncs,
    output logic                            miso,
    output logic [2:0]                      major_mode,
    output logic [DATA_W-1:0]               conf_word,
    output logic [DATA_W-1:0]               divisor,
    output logic [NUM_USER_REGS*DATA_W-1:0] user_regs,
    output logic                            conf_strobe,
    output logic [3:0]                      frame_err_cnt
);

    localparam int FRAME_W = 16;
    localparam int CNT_W   = 5;
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [DATA_W-1:0] THR_VAL  = DATA_W'(DEFAULT_THR);

    localparam logic [3:0] OP_CONF = 4'h1;
    localparam logic [3:0] OP_DIV  = 4'h2;
    localparam logic [3:0] OP_USR0 = 4'h3;

    // Sync chains: [0] first flop, [1] synchronised value, [2] edge-detect history
    logic [2:0] spck_sync;
    logic [2:0] ncs_sync;
    logic [2:0] mosi_sync;

    logic spck_rise;
    logic ncs_rise;
    logic ncs_fall;
    logic mosi_s;

    logic [FRAME_W-1:0] shift_reg;
    logic [FRAME_W-1:0] shift_nx;
    logic [CNT_W-1:0]   bit_cnt;
    logic [CNT_W-1:0]   bit_cnt_nx;
    logic               shift_en;

    logic               frame_ok;
    logic               frame_bad;
    logic [3:0]         op;
    logic [DATA_W-1:0]  d;
    logic               conf_wr;

    logic [DATA_W-1:0]  user_q [NUM_USER_REGS];

    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            spck_sync <= 3'b000;
            ncs_sync  <= 3'b111;
            mosi_sync <= 3'b000;
        end else begin
            spck_sync <= {spck_sync[1:0], spck};
            ncs_sync  <= {ncs_sync[1:0], ncs};
            mosi_sync <= {mosi_sync[1:0], mosi};
        end
    end

    assign spck_rise = spck_sync[1] & ~spck_sync[2];
    assign ncs_rise  = ncs_sync[1] & ~ncs_sync[2];
    assign ncs_fall  = ~ncs_sync[1] & ncs_sync[2];
    assign mosi_s    = mosi_sync[1];

    // Gating on the delayed ncs lets a final spck edge that coincides with the
    // ncs rising edge still shift in before the frame is decoded.
    assign shift_en = spck_rise & ~ncs_sync[2];

    always_comb begin
        shift_nx   = shift_reg;
        bit_cnt_nx = bit_cnt;
        if (shift_en) begin
            shift_nx = {shift_reg[FRAME_W-2:0], mosi_s};
        end
        if (ncs_fall) begin
            bit_cnt_nx = '0;
        end else if (shift_en && (bit_cnt != CNT_SAT)) begin
            bit_cnt_nx = bit_cnt + 1'b1;
        end
    end

    assign op        = shift_nx[FRAME_W-1:FRAME_W-4];
    assign d         = shift_nx[DATA_W-1:0];
    assign frame_ok  = ncs_rise & (bit_cnt_nx == CNT_FULL);
    assign frame_bad = ncs_rise & (bit_cnt_nx != CNT_FULL);
    assign conf_wr   = frame_ok & (op == OP_CONF);

    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            shift_reg <= '0;
            bit_cnt   <= '0;
        end else begin
            shift_reg <= shift_nx;
            bit_cnt   <= bit_cnt_nx;
        end
    end

    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            conf_word     <= '0;
            divisor       <= '0;
            conf_strobe   <= 1'b0;
            frame_err_cnt <= '0;
            for (int k = 0; k < NUM_USER_REGS; k++) begin
                user_q[k] <= '0;
            end
        end else begin
            conf_strobe <= conf_wr;
            if (frame_bad && (frame_err_cnt != 4'hF)) begin
                frame_err_cnt <= frame_err_cnt + 4'h1;
            end
            if (conf_wr) begin
                conf_word <= d;
            end
            if (frame_ok && (op == OP_DIV)) begin
                divisor <= d;
            end
            for (int k = 0; k < NUM_USER_REGS; k++) begin
                if (frame_ok && (op == OP_USR0 + 4'(k))) begin
                    user_q[k] <= d;
                end
            end
            // Selecting the edge-detect mode also restores its default threshold
            if (conf_wr && (d == EDGE_CONF)) begin
                user_q[0] <= THR_VAL;
            end
        end
    end

    for (genvar g = 0; g < NUM_USER_REGS; g++) begin : g_user_flat
        assign user_regs[g*DATA_W +: DATA_W] = user_q[g];
    end

    assign major_mode = conf_word[DATA_W-1:DATA_W-3];

`ifdef LF_CMD_READBACK_EN
    localparam logic [3:0] OP_RDSEL = 4'hF;

    logic                spck_fall;
    logic [3:0]          rb_sel;
    logic [DATA_W-1:0]   rb_data;
    logic [FRAME_W-1:0]  shadow;

    assign spck_fall = ~spck_sync[1] & spck_sync[2];

    always_comb begin
        rb_data = '0;
        if (rb_sel == 4'd0) begin
            rb_data = conf_word;
        end else if (rb_sel == 4'd1) begin
            rb_data = divisor;
        end else begin
            for (int k = 0; k < NUM_USER_REGS; k++) begin
                if (rb_sel == 4'(k + 2)) begin
                    rb_data = user_q[k];
                end
            end
        end
    end

    // Shadow is captured at frame start so the ARM reads a stable snapshot
    always_ff @(posedge pck0 or posedge rst) begin
        if (rst) begin
            rb_sel <= '0;
            shadow <= '0;
        end else begin
            if (frame_ok && (op == OP_RDSEL)) begin
                rb_sel <= d[3:0];
            end
            if (ncs_fall) begin
                shadow <= {rb_data, {(FRAME_W-DATA_W){1'b0}}};
            end else if (spck_fall) begin
                shadow <= {shadow[FRAME_W-2:0], 1'b0};
            end
        end
    end

    assign miso = ~ncs_sync[1] & shadow[FRAME_W-1];
`else
    assign miso = 1'b0;
`endif

endmodule

// File: tb/tb_lf_cmd_decoder.sv
// Directed testbench for lf_cmd_decoder: SPI frames driven MSB first with spck well
// below pck0/4; outputs sampled on pck0 falling edges.
module tb_lf_cmd_decoder;

    localparam int DATA_W        = 8;
    localparam int NUM_USER_REGS = 2;
    localparam int HALF          = 50;

    logic                            pck0 = 1'b0;
    logic                            rst  = 1'b1;
    logic                            spck = 1'b0;
    logic                            mosi = 1'b0;
    logic                            ncs  = 1'b1;
    logic                            miso;
    logic [2:0]                      major_mode;
    logic [DATA_W-1:0]               conf_word;
    logic [DATA_W-1:0]               divisor;
    logic [NUM_USER_REGS*DATA_W-1:0] user_regs;
    logic                            conf_strobe;
    logic [3:0]                      frame_err_cnt;

    int pass_cnt    = 0;
    int check_cnt   = 0;
    int strobe_seen = 0;

    logic [0:0] exp_q[$];

    lf_cmd_decoder #(
        .DATA_W(DATA_W),
        .NUM_USER_REGS(NUM_USER_REGS),
        .EDGE_CONF(8'h01),
        .DEFAULT_THR(127)
    ) dut (
        .pck0(pck0),
        .rst(rst),
        .spck(spck),
        .mosi(mosi),
        .ncs(ncs),
        .miso(miso),
        .major_mode(major_mode),
        .conf_word(conf_word),
        .divisor(divisor),
        .user_regs(user_regs),
        .conf_strobe(conf_strobe),
        .frame_err_cnt(frame_err_cnt)
    );

    // clock / reset
    always #5 pck0 = ~pck0;

    always @(negedge pck0) begin
        if (conf_strobe) strobe_seen++;
    end

    task automatic apply_reset();
        rst = 1'b1; ncs = 1'b1; spck = 1'b0; mosi = 1'b0;
        repeat (4) @(negedge pck0);
        rst = 1'b0;
        repeat (4) @(negedge pck0);
    endtask

    // driver: nbits of val MSB first; rb collects miso sampled before each rising spck
    task automatic send_frame(input logic [16:0] val, input int nbits, output logic [16:0] rb);
        rb = '0;
        ncs = 1'b0;
        #(2*HALF);
        for (int i = 0; i < nbits; i++) begin
            mosi = val[nbits-1-i];
            #(HALF-10);
            rb = {rb[15:0], miso};
            #10;
            spck = 1'b1;
            #HALF;
            spck = 1'b0;
        end
        #(2*HALF);
        ncs  = 1'b1;
        mosi = 1'b0;
        repeat (10) @(negedge pck0);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge pck0);
        check_cnt++; if (conf_word !== 8'h00) $display("FAIL reset_conf got=%h exp=00", conf_word); else pass_cnt++;
        check_cnt++; if (divisor !== 8'h00) $display("FAIL reset_div got=%h exp=00", divisor); else pass_cnt++;
        check_cnt++; if (user_regs !== 16'h0000) $display("FAIL reset_user got=%h exp=0000", user_regs); else pass_cnt++;
        check_cnt++; if (frame_err_cnt !== 4'h0) $display("FAIL reset_err got=%h exp=0", frame_err_cnt); else pass_cnt++;
        check_cnt++; if (conf_strobe !== 1'b0) $display("FAIL reset_strobe got=%b exp=0", conf_strobe); else pass_cnt++;
        check_cnt++; if (miso !== 1'b0) $display("FAIL reset_miso got=%b exp=0", miso); else pass_cnt++;
        apply_reset();
    endtask

    task automatic test_conf_write();
        logic [16:0] rb;
        int s0;
        s0 = strobe_seen;
        send_frame(17'h01021, 16, rb);
        check_cnt++; if (conf_word !== 8'h21) $display("FAIL conf_word got=%h exp=21", conf_word); else pass_cnt++;
        check_cnt++; if (major_mode !== 3'b001) $display("FAIL major_mode got=%b exp=001", major_mode); else pass_cnt++;
        check_cnt++; if (strobe_seen - s0 != 1) $display("FAIL conf_strobe_cycles got=%0d exp=1", strobe_seen - s0); else pass_cnt++;
        check_cnt++; if (divisor !== 8'h00) $display("FAIL conf_div got=%h exp=00", divisor); else pass_cnt++;
        check_cnt++; if (frame_err_cnt !== 4'h0) $display("FAIL conf_err got=%h exp=0", frame_err_cnt); else pass_cnt++;
    endtask

    task automatic test_edge_conf();
        logic [16:0] rb;
        send_frame(17'h03055, 16, rb);
        check_cnt++; if (user_regs[7:0] !== 8'h55) $display("FAIL user0_write got=%h exp=55", user_regs[7:0]); else pass_cnt++;
        send_frame(17'h01001, 16, rb);
        check_cnt++; if (user_regs[7:0] !== 8'd127) $display("FAIL edge_thr got=%h exp=7f", user_regs[7:0]); else pass_cnt++;
        check_cnt++; if (conf_word !== 8'h01) $display("FAIL edge_conf got=%h exp=01", conf_word); else pass_cnt++;
    endtask

    task automatic test_div_user();
        logic [16:0] rb;
        send_frame(17'h02005, 16, rb);
        send_frame(17'h04033, 16, rb);
        check_cnt++; if (divisor !== 8'h05) $display("FAIL div_write got=%h exp=05", divisor); else pass_cnt++;
        check_cnt++; if (user_regs[15:8] !== 8'h33) $display("FAIL user1_write got=%h exp=33", user_regs[15:8]); else pass_cnt++;
        send_frame(17'h05077, 16, rb);
        check_cnt++; if (user_regs !== 16'h337F) $display("FAIL op5_user got=%h exp=337f", user_regs); else pass_cnt++;
        check_cnt++; if (divisor !== 8'h05) $display("FAIL op5_div got=%h exp=05", divisor); else pass_cnt++;
        check_cnt++; if (conf_word !== 8'h01) $display("FAIL op5_conf got=%h exp=01", conf_word); else pass_cnt++;
        check_cnt++; if (frame_err_cnt !== 4'h0) $display("FAIL op5_err got=%h exp=0", frame_err_cnt); else pass_cnt++;
    endtask

    task automatic test_frame_err();
        logic [16:0] rb;
        send_frame(17'h01234, 15, rb);
        send_frame(17'h12055, 17, rb);
        check_cnt++; if (frame_err_cnt !== 4'h2) $display("FAIL err_two got=%h exp=2", frame_err_cnt); else pass_cnt++;
        check_cnt++; if (divisor !== 8'h05) $display("FAIL err_div got=%h exp=05", divisor); else pass_cnt++;
        check_cnt++; if (conf_word !== 8'h01) $display("FAIL err_conf got=%h exp=01", conf_word); else pass_cnt++;
        for (int i = 0; i < 16; i++) begin
            send_frame(17'h01111, 14, rb);
        end
        check_cnt++; if (frame_err_cnt !== 4'hF) $display("FAIL err_sat got=%h exp=f", frame_err_cnt); else pass_cnt++;
    endtask

    task automatic test_reset_mid_frame();
        logic [16:0] rb;
        logic [7:0]  hi;
        hi = 8'h20;
        ncs = 1'b0;
        #(2*HALF);
        for (int i = 0; i < 8; i++) begin
            mosi = hi[7-i];
            #HALF; spck = 1'b1;
            #HALF; spck = 1'b0;
        end
        rst = 1'b1;
        ncs = 1'b1;
        mosi = 1'b0;
        repeat (4) @(negedge pck0);
        check_cnt++; if (divisor !== 8'h00) $display("FAIL midrst_div got=%h exp=00", divisor); else pass_cnt++;
        rst = 1'b0;
        repeat (6) @(negedge pck0);
        send_frame(17'h020FF, 16, rb);
        check_cnt++; if (divisor !== 8'hFF) $display("FAIL midrst_clean_div got=%h exp=ff", divisor); else pass_cnt++;
        check_cnt++; if (frame_err_cnt !== 4'h0) $display("FAIL midrst_err got=%h exp=0", frame_err_cnt); else pass_cnt++;
        check_cnt++; if (conf_word !== 8'h00) $display("FAIL midrst_conf got=%h exp=00", conf_word); else pass_cnt++;
    endtask

    task automatic test_readback();
        logic [16:0] rb;
        logic [15:0] exp_bits;
        logic [0:0]  e;
        send_frame(17'h0205A, 16, rb);
        send_frame(17'h0F001, 16, rb);
        check_cnt++; if (conf_word !== 8'h00) $display("FAIL rdsel_conf got=%h exp=00", conf_word); else pass_cnt++;
        check_cnt++; if (miso !== 1'b0) $display("FAIL miso_idle got=%b exp=0", miso); else pass_cnt++;
`ifdef LF_CMD_READBACK_EN
        exp_bits = 16'h5A00;
`else
        exp_bits = 16'h0000;
`endif
        for (int i = 15; i >= 0; i--) exp_q.push_back(exp_bits[i]);
        send_frame(17'h00000, 16, rb);
        for (int i = 15; i >= 0; i--) begin
            e = exp_q.pop_front();
            check_cnt++;
            if (rb[i] !== e[0]) $display("FAIL miso_bit%0d got=%b exp=%b", 15 - i, rb[i], e[0]);
            else pass_cnt++;
        end
        check_cnt++; if (frame_err_cnt !== 4'h0) $display("FAIL rb_err got=%h exp=0", frame_err_cnt); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_conf_write();
        test_edge_conf();
        test_div_user();
        test_frame_err();
        test_reset_mid_frame();
        apply_reset();
        test_readback();
        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
